// File: rtl/player_input.sv
// player_input: decodes one player's keycode against its control map once per VGA frame and
// produces held/act vectors. Define PLAYER_INPUT_REPEAT_EN for typematic auto-repeat.
module player_input #(
    parameter logic [7:0] REPEAT_DELAY = 8'd20,
    parameter logic [7:0] REPEAT_RATE  = 8'd4,
    parameter logic [7:0] REPEAT_MASK  = 8'b0011_1111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic [63:0] controls,
    output logic        frame_tick,
    output logic [7:0]  held,
    output logic [7:0]  act,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
`ifdef PLAYER_INPUT_REPEAT_EN
    localparam logic [1:0] ST_PRESS = 2'd1;  // DELAY: counting toward first repeat
    localparam logic [1:0] ST_RPT   = 2'd2;
`else
    localparam logic [1:0] ST_PRESS = 2'd1;  // HELD
    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_DELAY, REPEAT_RATE, REPEAT_MASK};
`endif

    logic       sync1_q, sync2_q, prev_q, tick_q;
    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] held_q, held_d;
    logic [7:0] act_q, act_d;
`ifdef PLAYER_INPUT_REPEAT_EN
    logic [7:0] cnt_q, cnt_d;
`endif

    logic       hit;
    logic [2:0] hit_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            tick_q  <= sync2_q & ~prev_q;
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (keycode != 8'd0 && controls[63-8*i -: 8] == keycode) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        held_d  = held_q;
        act_d   = 8'd0;
`ifdef PLAYER_INPUT_REPEAT_EN
        cnt_d   = cnt_q;
`endif
        if (tick_q) begin
            if (!hit) begin
                state_d = ST_IDLE;
                held_d  = 8'd0;
            end else if (state_q == ST_IDLE || hit_idx != idx_q) begin
                state_d = ST_PRESS;
                idx_d   = hit_idx;
                held_d  = 8'b1 << hit_idx;
                act_d   = 8'b1 << hit_idx;
`ifdef PLAYER_INPUT_REPEAT_EN
                cnt_d   = REPEAT_DELAY - 8'd1;
`endif
            end
`ifdef PLAYER_INPUT_REPEAT_EN
            else if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end else if (state_q == ST_RPT || REPEAT_MASK[idx_q]) begin
                // Non-repeating actions fall through and sit in DELAY with cnt at 0.
                act_d   = 8'b1 << idx_q;
                cnt_d   = REPEAT_RATE - 8'd1;
                state_d = ST_RPT;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            held_q  <= 8'd0;
            act_q   <= 8'd0;
`ifdef PLAYER_INPUT_REPEAT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            held_q  <= held_d;
            act_q   <= act_d;
`ifdef PLAYER_INPUT_REPEAT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign frame_tick = tick_q;
    assign held       = held_q;
    assign act        = act_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/player_input.md
# player_input

Per-player input conditioner between the USB keycode path and the `player` block. It decodes one player's 8-bit keycode against that player's 64-bit control map and synchronises everything to the VGA frame strobe. It produces level (`held`) and single-cycle action (`act`) vectors, with typematic auto-repeat on movement/aim actions. One instance per player; `act`/`held` feed `player` so its motion logic no longer compares raw keycodes.

## Interface
- `REPEAT_DELAY`, 20: frames from initial press to first repeat pulse; legal range 1..255.
- `REPEAT_RATE`, 4: frames between subsequent repeat pulses; legal range 1..255.
- `REPEAT_MASK`, 8'b0011_1111: actions eligible for auto-repeat. Bit i set means action i may repeat.
- `clk`  in  1  system clock (CLOCK_50).
- `reset`  in  1  asynchronous, active-high reset.
- `frame_clk`  in  1  VGA vertical sync (VGA_VS), asynchronous to `clk`.
- `keycode`  in  8  current USB keycode for this player; 0 = no key.
- `controls`  in  64  control map. Action i's keycode is `controls[63-8i -: 8]`.
  - Index order: 0 up, 1 down, 2 left, 3 right, 4 rot_ccw, 5 rot_cw, 6 fire_a, 7 fire_b.
- `frame_tick`  out  1  one-`clk` pulse per frame_clk rising edge.
- `held`  out  8  one-hot or zero, frame-synchronous level of the matched action.
- `act`  out  8  one-`clk` pulse on a new press or a repeat event.

## Operation
- **Frame sync.** `frame_clk` passes through a 2-flop synchroniser plus an edge register. `frame_tick` = synced & ~previous.
- **Decode.** On `frame_tick`, `keycode` is compared against all 8 map entries.
  - The lowest matching index wins.
  - `keycode==0` never matches, even if a map entry is 0.
  - No match gives `match_idx` = none.
- **FSM states.**
  - IDLE: no action held.
  - DELAY: counting toward the first repeat.
  - RPT: counting between repeats.
- **FSM transitions** are evaluated only on `frame_tick`.
  - Any state, no match: go to IDLE, `held`=0.
  - IDLE, match i: `act[i]` pulse, `held`=1<<i, `cnt`=REPEAT_DELAY-1, go to DELAY.
  - DELAY/RPT, match differs from the current index: same as a fresh press of the new index. The new index gets an `act` pulse, re-enters DELAY and reloads `cnt`. No release frame is required.
  - DELAY, same index, `cnt`!=0: `cnt`-=1.
  - DELAY, same index, `cnt`==0: if `REPEAT_MASK[i]`, `act[i]` pulse, `cnt`=REPEAT_RATE-1, go to RPT. Otherwise stay in DELAY with `cnt` held at 0.
  - RPT, same index, `cnt`!=0: `cnt`-=1.
  - RPT, same index, `cnt`==0: `act[i]` pulse, `cnt`=REPEAT_RATE-1.
- **Repeat timing.** A press first seen on frame N yields pulses on frames N, N+REPEAT_DELAY, N+REPEAT_DELAY+REPEAT_RATE, and so on.
- **Fire actions** (mask bits clear) pulse exactly once per continuous hold.
- **Widths.** `cnt` is 8 bits and unsigned. It never underflows, because a zero is always reloaded or held.
- **Between frames.** Changes to `keycode` or `controls` between ticks are ignored.

## Timing
- **Reset values.** On reset assertion, `frame_tick`, `held`, `act`, `cnt` and the synchroniser flops are 0, and state = IDLE.
- **Reset mid-hold.** Reset asserted during a hold clears state immediately. After release, a still-held key produces a fresh press pulse on the next `frame_tick`.
- **frame_tick latency.** Asserted 3 `clk` edges after a rising edge of `frame_clk`.
- **Decode latency.** `keycode` is sampled in the `frame_tick` cycle. `held` and `act` update on the following `clk` edge: 1-cycle latency.
- **act width.** `act` is high for exactly one `clk` cycle. At most one `act` bit is set at any time.
- **held stability.** `held` is stable for a whole frame.
- **First-edge rule.** A `frame_clk` edge during the first cycle after reset release is not guaranteed to tick.

## Configuration
- `PLAYER_INPUT_REPEAT_EN` defined:
  - Full behaviour above.
- `PLAYER_INPUT_REPEAT_EN` undefined:
  - The counter is removed and the FSM reduces to IDLE/HELD.
  - `act` pulses only on a new press or a change of action.
  - `REPEAT_*` parameters are ignored.
  - `held` and `frame_tick` are unchanged.

## Test plan
All scenarios use the player 1 map: W=26, S=22, A=04, D=07, Q=20, E=08, 1=30, 3=32.
- **Reset.** Assert `reset` with frame_clk toggling → all outputs 0. Release with `keycode`=0 → no `act` over 5 frames.
- **Single press.** `keycode`=26 for 1 frame, then 0:
  - `act`=8'h01 for one cycle, 4 clk after the edge.
  - `held`=8'h01 for one frame, then 0.
- **Auto-repeat.** `keycode`=04 held for 30 frames (D=20, R=4) → `act[2]` on frames 0, 20, 24, 28 only; exactly 4 pulses.
- **Fire, no repeat.** `keycode`=30 held for 40 frames → exactly one `act[6]` pulse; `held`=8'h40 throughout.
- **Key change and unmapped key.** `keycode`=04 for 10 frames, then 07 → `act[3]` on the change frame, repeat at +20. `keycode`=99 → `held`=0, no `act`.
- **Duplicate map and reset mid-hold.** Map entries 0 and 2 both =26, `keycode`=26 → only bit 0 set. Assert `reset` during a hold, then release → new `act[0]` on the next frame.
- **Macro undefined.** Rerun the auto-repeat scenario → a single `act[2]` pulse.
